multicycle_core: RTL
====================

// Module: multicycle_core
// PURPOSE
//  Parametrised 4-state (fetch/decode/execute/writeback) core for the board-level CPU.
//  Generalises the fixed 2-register, 2-opcode 8-bit-instruction control unit:
//   - register count and data width are parameters;
//   - 8 ALU ops, immediate mode, zero/carry flags;
//   - valid/ready instruction handshake;
//   - debug read port for HEX/LEDR display logic.
//  Sits between the instruction source (switch latch or future ROM sequencer) and the display wrappers.
// PARAMETERS
//  DATA_W   32  register/ALU width in bits (>=4)
//  NUM_REGS 4   register-file entries, power of two, >=2
//  REG_AW   $clog2(NUM_REGS)  register-field width (derived, do not override)
//  INSTR_W  4+2*REG_AW        instruction width (derived; 8 at defaults)
// PORTS
//  clock_pulse   in   1        single clock; all state changes on rising edge only
//  resetn        in   1        asynchronous, active-low reset
//  instr_valid   in   1        source presents a valid instruction on instr
//  instr         in   INSTR_W  {mode, opcode[2:0], ra[REG_AW-1:0], rb[REG_AW-1:0]}
//  instr_ready   out  1        core accepts instr this cycle (high only in FETCH)
//  state         out  2        00 FETCH, 01 DECODE, 10 EXECUTE, 11 WRITEBACK
//  retire        out  1        one-cycle pulse in the WRITEBACK cycle
//  flag_zero     out  1        last ALU result == 0
//  flag_carry    out  1        carry out (ADD/INC) or borrow (SUB); 0 for logic ops
//  dbg_addr      in   REG_AW   debug register select
//  dbg_data      out  DATA_W   combinational read of regs[dbg_addr]
// BEHAVIOUR
//  Reset (async, resetn=0): state=FETCH; all regs, IR, operand latches, result, flags = 0; retire=0.
//  FETCH: instr_ready=1.
//   - instr_valid=1 at the edge: IR<=instr, go to DECODE.
//   - Otherwise stay in FETCH indefinitely.
//  DECODE: A<=regs[ra].
//   - mode=0: B<=regs[rb].
//   - mode=1: B<=zero-extended rb field (immediate).
//   - Always go to EXECUTE.
//  EXECUTE: result<=op(A,B); always go to WRITEBACK. Opcodes:
//   000 NOP  no result; flags unchanged
//   001 ADD  A+B
//   010 SUB  A-B
//   011 INC  B+1
//   100 AND  A&B
//   101 OR   A|B
//   110 XOR  A^B
//   111 MOV  B
//  Arithmetic: modulo 2^DATA_W; carry = bit DATA_W of the (DATA_W+1)-bit sum.
//   - SUB: carry=1 iff A<B (unsigned).
//   - AND/OR/XOR/MOV: carry=0.
//   - Flags update at the EXECUTE edge for every op except NOP.
//  WRITEBACK: regs[ra]<=result unless NOP; retire=1; go to FETCH.
//  Latency: accept-to-retire = 3 cycles; 4 cycles per instruction minimum.
//   - Written value appears on dbg_data the cycle after WRITEBACK.
//  ra==rb is legal; both operands read the same pre-instruction value.
//  instr/instr_valid are ignored outside FETCH; no queuing.
//  Reset mid-instruction aborts it: no write, no retire; FETCH on release.
//  Unreachable state encodings are impossible (2-bit, all used); the default branch returns to FETCH.
// TESTING (DATA_W=32, NUM_REGS=4, 8-bit instr)
//  1. Reset, then instr_valid=0 for 5 cycles -> state=00, instr_ready=1, retire never pulses, all regs 0.
//  2. Send 0xF3 (MOV R0,#3), then 0xF6 (MOV R1,#2) -> R0=3, R1=2; retire once per instruction, 4 cycles apart.
//  3. Send 0x11 (ADD R0,R1) -> R0=5, zero=0, carry=0.
//     Then 0x24 (SUB R1,R0) -> R1=0xFFFFFFFD, carry=1.
//  4. Send 0xA9 (SUB R2,#1 from R2=0) -> R2=0xFFFFFFFF, carry=1.
//     Then 0x3A (INC R2) -> R2=0, zero=1, carry=1.
//  5. Send 0x0x (NOP) after test 4 -> no register changes, flags stay zero=1 carry=1, retire still pulses.
//  6. Accept 0xF7 (MOV R1,#3); drop resetn during EXECUTE -> R1=0, state=FETCH, no retire.
//     After release, 0xF7 is applied again -> R1=3.

Source files
------------

// File: rtl/multicycle_core_if.sv
// Instruction handshake bundle between an instruction source and the core.
// Ports: instr_valid/instr from the source, instr_ready back from the core.
interface multicycle_core_if #(
    parameter int INSTR_W = 8
);
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic               instr_ready;

    modport master (
        output instr_valid,
        output instr,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready
    );
endinterface

// File: rtl/multicycle_core.sv
// Four-state fetch/decode/execute/writeback core with flags and debug read.
// Ports: clock_pulse, resetn, ibus (slave handshake), state, retire,
// flag_zero, flag_carry, dbg_addr in, dbg_data out.
module multicycle_core #(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 4,
    localparam int REG_AW   = $clog2(NUM_REGS),
    localparam int INSTR_W  = 4 + 2 * REG_AW
) (
    input  logic              clock_pulse,
    input  logic              resetn,
    multicycle_core_if.slave  ibus,
    output logic [1:0]        state,
    output logic              retire,
    output logic              flag_zero,
    output logic              flag_carry,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {
        FETCH     = 2'b00,
        DECODE    = 2'b01,
        EXECUTE   = 2'b10,
        WRITEBACK = 2'b11
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_INC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;

    state_t              state_q, state_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                zf_q, zf_d;
    logic                cf_q, cf_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];

    logic                mode;
    logic [2:0]          op;
    logic [REG_AW-1:0]   ra;
    logic [REG_AW-1:0]   rb;
    logic [DATA_W:0]     alu;

    assign mode = ir_q[INSTR_W-1];
    assign op   = ir_q[INSTR_W-2 -: 3];
    assign ra   = ir_q[2*REG_AW-1 -: REG_AW];
    assign rb   = ir_q[REG_AW-1:0];

    // One extra bit on top carries out of ADD/INC and the borrow of SUB.
    always_comb begin
        alu = '0;
        case (op)
            OP_ADD:  alu = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB:  alu = {1'b0, a_q} - {1'b0, b_q};
            OP_INC:  alu = {1'b0, b_q} + (DATA_W+1)'(1);
            OP_AND:  alu = {1'b0, a_q & b_q};
            OP_OR:   alu = {1'b0, a_q | b_q};
            OP_XOR:  alu = {1'b0, a_q ^ b_q};
            default: alu = {1'b0, b_q};
        endcase
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        zf_d    = zf_q;
        cf_d    = cf_q;
        regs_d  = regs_q;
        retire  = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (ibus.instr_valid) begin
                    ir_d    = ibus.instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d = regs_q[ra];
                if (mode) begin
                    b_d = {{(DATA_W-REG_AW){1'b0}}, rb};
                end else begin
                    b_d = regs_q[rb];
                end
                state_d = EXECUTE;
            end
            EXECUTE: begin
                if (op != OP_NOP) begin
                    res_d = alu[DATA_W-1:0];
                    cf_d  = alu[DATA_W];
                    zf_d  = (alu[DATA_W-1:0] == '0);
                end
                state_d = WRITEBACK;
            end
            WRITEBACK: begin
                if (op != OP_NOP) begin
                    regs_d[ra] = res_q;
                end
                retire  = 1'b1;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock_pulse or negedge resetn) begin
        if (!resetn) begin
            state_q <= FETCH;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            zf_q    <= 1'b0;
            cf_q    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            zf_q    <= zf_d;
            cf_q    <= cf_d;
            regs_q  <= regs_d;
        end
    end

    assign ibus.instr_ready = (state_q == FETCH);
    assign state            = state_q;
    assign flag_zero        = zf_q;
    assign flag_carry       = cf_q;
    assign dbg_data         = regs_q[dbg_addr];

endmodule
